// File: rtl/tdm_mux_tx.sv
// tdm_mux_tx: captures one word per lane and sends the frame serially, lane 0
// first, each lane MSB first. A frame strobe and the lane index travel with
// every bit so the receiving demux can route it back to its lane.
//
// Handshake: a frame is accepted on a rising edge where load_valid and
// load_ready are both 1. load_ready depends only on state and counters. It is
// 1 in IDLE and on the last bit of a frame, which allows back-to-back frames
// with no gap. load_valid while load_ready is 0 is ignored, not queued.
module tdm_mux_tx #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS*WIDTH-1:0]     ch_data,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic                          tx_bit,
  output logic                          tx_valid,
  output logic                          tx_frame,
  output logic [$clog2(CHANNELS)-1:0]   tx_sel
);

  localparam int FRAME_BITS = CHANNELS * WIDTH;
  localparam int CH_W       = $clog2(CHANNELS);
  localparam int BIT_W      = $clog2(WIDTH);

  // Explicit wrap points, so a WIDTH that is not a power of two never relies
  // on counter overflow.
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CH_W-1:0]         ch_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   frame_ordered;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    tx_bit_q;
  logic                    tx_frame_q;
  logic                    last_bit;
  logic                    capture;

  // Lane 0 goes to the top of the frame register, so shifting out from the
  // MSB yields lane 0 MSB first, then lane 1, and so on.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_order
    assign frame_ordered[(CHANNELS-1-k)*WIDTH +: WIDTH] = ch_data[k*WIDTH +: WIDTH];
  end

  assign last_bit   = (state == SHIFT) && (ch_cnt == CH_LAST) && (bit_cnt == BIT_LAST);
  assign load_ready = (state == IDLE) || last_bit;
  assign capture    = load_ready && load_valid;

  // The counters always describe the bit currently on tx_bit.
  assign tx_bit   = tx_bit_q;
  assign tx_frame = tx_frame_q;
  assign tx_valid = (state == SHIFT);
  assign tx_sel   = ch_cnt;

  // Next-state logic: leave SHIFT only when the last bit goes without a reload.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_valid) state_next = SHIFT;
      SHIFT:   if (last_bit && !load_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: on load, present bit 0 at once. In SHIFT, step to the next bit.
  // Otherwise, return outputs and counters to their idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      tx_bit_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      ch_cnt     <= '0;
      bit_cnt    <= '0;
    end else if (capture) begin
      shift_q    <= {frame_ordered[FRAME_BITS-2:0], 1'b0};
      tx_bit_q   <= frame_ordered[FRAME_BITS-1];
      tx_frame_q <= 1'b1;
      ch_cnt     <= '0;
      bit_cnt    <= '0;
    end else if (state == SHIFT && !last_bit) begin
      shift_q    <= {shift_q[FRAME_BITS-2:0], 1'b0};
      tx_bit_q   <= shift_q[FRAME_BITS-1];
      tx_frame_q <= 1'b0;
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
        ch_cnt  <= ch_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      tx_bit_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      ch_cnt     <= '0;
      bit_cnt    <= '0;
    end
  end

endmodule

// File: tb/tb_tdm_mux_tx.sv
// tb_tdm_mux_tx: directed and random stimulus for tdm_mux_tx (4x8 and 2x5).
// The reference is a queue of the bits expected on the line, built directly
// from the frame layout: lane 0 first, each lane MSB first.
module tb_tdm_mux_tx;

  localparam int C = 4;
  localparam int W = 8;
  localparam int N = C * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT 4x8 ----------------
  logic [N-1:0] ch_data;
  logic         load_valid;
  logic         load_ready;
  logic         tx_bit;
  logic         tx_valid;
  logic         tx_frame;
  logic [1:0]   tx_sel;

  tdm_mux_tx #(.CHANNELS(C), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_data    (ch_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .tx_bit     (tx_bit),
    .tx_valid   (tx_valid),
    .tx_frame   (tx_frame),
    .tx_sel     (tx_sel)
  );

  // ---------------- DUT 2x5 (non power-of-two width) ----------------
  logic [9:0] d5;
  logic       lv5;
  logic       ready5;
  logic       bit5;
  logic       valid5;
  logic       frame5;
  logic       sel5;

  tdm_mux_tx #(.CHANNELS(2), .WIDTH(5)) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_data    (d5),
    .load_valid (lv5),
    .load_ready (ready5),
    .tx_bit     (bit5),
    .tx_valid   (valid5),
    .tx_frame   (frame5),
    .tx_sel     (sel5)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [3:0]   exp_q[$];      // {frame, sel[1:0], bit} per expected line cycle
  logic [N-1:0] frame_q[$];    // accepted frames awaiting reconstruction
  logic [W-1:0] rec [C];       // receiver-side lane registers
  int           rec_bits = 0;
  logic [N-1:0] stream;        // serial bits, first bit ends up in the MSB
  logic [2*N-1:0] sel_log;
  int           valid_cnt;
  int           frame_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the line image of one accepted frame.
  task automatic push_frame(input logic [N-1:0] d);
    for (int k = 0; k < C; k++)
      for (int b = W - 1; b >= 0; b--)
        exp_q.push_back({(k == 0 && b == W - 1) ? 1'b1 : 1'b0, 2'(k), d[k*W + b]});
    frame_q.push_back(d);
  endtask

  task automatic clear_logs();
    stream    = '0;
    sel_log   = '0;
    valid_cnt = 0;
    frame_cnt = 0;
  endtask

  // One cycle, called at a falling edge: check the line against the model,
  // run the demux receiver, drive the inputs, advance the model by one edge.
  task automatic step(input logic lv, input logic [N-1:0] d);
    logic [3:0]   e;
    logic         exp_valid;
    logic         exp_ready;
    logic [N-1:0] got;
    exp_valid = (exp_q.size() > 0);
    e         = exp_valid ? exp_q[0] : 4'b0000;
    exp_ready = (exp_q.size() <= 1);
    check("cycle{valid,frame,sel,bit,ready}",
          64'({tx_valid, tx_frame, tx_sel, tx_bit, load_ready}),
          64'({exp_valid, e[3], e[2:1], e[0], exp_ready}));
    if (tx_valid) begin
      valid_cnt++;
      if (tx_frame) begin
        frame_cnt++;
        rec_bits = 0;
      end
      stream  = {stream[N-2:0], tx_bit};
      sel_log = {sel_log[2*N-3:0], tx_sel};
      rec[tx_sel] = {rec[tx_sel][W-2:0], tx_bit};
      rec_bits++;
      if (rec_bits == N) begin
        for (int k = 0; k < C; k++) got[k*W +: W] = rec[k];
        check("sb_frame", 64'(got), (frame_q.size() > 0) ? 64'(frame_q.pop_front()) : 64'hx);
        rec_bits = 0;
      end
    end
    load_valid = lv;
    ch_data    = d;
    if (exp_valid) void'(exp_q.pop_front());
    if (exp_ready && lv) push_frame(d);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] serial_of(input logic [N-1:0] d);
    logic [N-1:0] s;
    s = '0;
    for (int k = 0; k < C; k++)
      for (int b = W - 1; b >= 0; b--)
        s = {s[N-2:0], d[k*W + b]};
    return s;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [9:0] s5;
    logic [9:0] sl5;
    int         v5;
    int         f5;
    rst_n      = 1'b1;
    load_valid = 1'b0;
    ch_data    = '0;
    lv5        = 1'b0;
    d5         = '0;
    clear_logs();

    // Reset values, visible before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("reset_async", 64'({tx_valid, tx_frame, tx_sel, tx_bit, load_ready}), 64'b000001);
    check("reset_async_w5", 64'({valid5, frame5, sel5, bit5, ready5}), 64'b00001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_idle", 64'({tx_valid, tx_frame, tx_sel, tx_bit, load_ready}), 64'b000001);

    // Single frame from a one-cycle load pulse.
    clear_logs();
    step(1'b1, 32'hD4C3B2A1);
    repeat (33) step(1'b0, 32'h0);
    check("single_stream", 64'(stream), 64'hA1B2C3D4);
    check("single_sel", 64'(sel_log), 64'h0000_5555_AAAA_FFFF);
    check("single_frames", 64'(frame_cnt), 64'd1);
    check("single_valid_len", 64'(valid_cnt), 64'd32);

    // Back-to-back: load_valid held, data changes to the second frame mid-frame.
    clear_logs();
    step(1'b1, 32'hFFFF0000);
    repeat (32) step(1'b1, 32'h0000FFFF);
    repeat (33) step(1'b0, 32'h0);
    check("b2b_valid_len", 64'(valid_cnt), 64'd64);
    check("b2b_frames", 64'(frame_cnt), 64'd2);
    check("b2b_last_stream", 64'(stream), 64'(serial_of(32'h0000FFFF)));

    // Loads offered mid-frame are ignored.
    clear_logs();
    step(1'b1, 32'h11223344);
    repeat (10) step(1'b1, 32'h12345678);
    repeat (23) step(1'b0, 32'h0);
    check("ignored_stream", 64'(stream), 64'(serial_of(32'h11223344)));
    check("ignored_frames", 64'(frame_cnt), 64'd1);

    // Asynchronous reset while bit 13 is on the line.
    step(1'b1, 32'hAABBCCDD);
    repeat (13) step(1'b0, 32'h0);
    check("pre_reset_valid", 64'({tx_valid, tx_sel}), 64'b101);
    #2 rst_n = 1'b0;
    #1;
    check("midframe_reset", 64'({tx_valid, tx_frame, tx_sel, tx_bit, load_ready}), 64'b000001);
    #1 rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    frame_q.delete();
    rec_bits = 0;
    clear_logs();
    step(1'b1, 32'h0F1E2D3C);
    repeat (33) step(1'b0, 32'h0);
    check("after_reset_stream", 64'(stream), 64'(serial_of(32'h0F1E2D3C)));
    check("after_reset_sel", 64'(sel_log), 64'h0000_5555_AAAA_FFFF);

    // Two lanes of five bits.
    s5  = '0;
    sl5 = '0;
    v5  = 0;
    f5  = 0;
    lv5 = 1'b1;
    d5  = 10'b10110_01101;
    @(negedge clk);
    lv5 = 1'b0;
    d5  = '0;
    for (int i = 0; i < 10; i++) begin
      if (valid5) v5++;
      if (frame5) f5++;
      s5  = {s5[8:0], bit5};
      sl5 = {sl5[8:0], sel5};
      @(negedge clk);
    end
    check("w5_stream", 64'(s5), 64'(10'b01101_10110));
    check("w5_sel", 64'(sl5), 64'(10'b00000_11111));
    check("w5_valid_len", 64'(v5), 64'd10);
    check("w5_frames", 64'(f5), 64'd1);
    check("w5_end", 64'({valid5, ready5}), 64'b01);

    // Random stress, then drain.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, N'($urandom));
    repeat (40) step(1'b0, 32'h0);
    check("stress_drained", 64'(frame_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
